// File: rtl/inverter_loopback_checker_if.sv
// Tile pin bundle between the loopback checker and its surroundings.
// The checker takes the slave side; the harness or test driver takes the master side.
interface inverter_loopback_checker_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/inverter_loopback_checker.sv
// Digital-side loopback checker for the 3.3 V inverter macro: drives a square wave,
// checks that the returned signal is its inverse, and reports settle delay and error count.
module inverter_loopback_checker #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 12,
  parameter int HOLD_FIXED  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  inverter_loopback_checker_if.slave  pins
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT_RET,
    HOLD,
    DONE
  } state_e;

  localparam logic [3:0] TIMEOUT_C    = 4'(TIMEOUT);
  localparam logic [3:0] HOLD_FIXED_C = 4'(HOLD_FIXED);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] inv_sync_q;
  logic [SYNC_STAGES-1:0] start_sync_q;
  logic                   start_prev_q;
  logic                   stim_q, stim_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic                   mode_q, mode_d;
  logic                   hold_err_q, hold_err_d;
  logic [3:0]             max_delay_q, max_delay_d;
  logic [3:0]             delay_q, delay_d;
  logic [3:0]             hold_q, hold_d;
  logic [7:0]             err_count_q, err_count_d;
  logic [7:0]             lfsr_q, lfsr_d;
  logic [8:0]             trans_q, trans_d;

  logic       ret_sync;
  logic       start_edge;
  logic       ret_ok;
  logic       err_inc;
  logic [3:0] delay_inc;
  logic [3:0] hold_load;
  logic       lfsr_fb;
  logic       unused_pins;

  assign ret_sync   = inv_sync_q[SYNC_STAGES-1];
  assign start_edge = start_sync_q[SYNC_STAGES-1] & ~start_prev_q;
  assign ret_ok     = (ret_sync == ~stim_q);
  assign delay_inc  = delay_q + 4'd1;
  assign hold_load  = mode_q ? ({1'b0, lfsr_q[2:0]} + 4'd1) : HOLD_FIXED_C;
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign unused_pins = ^{pins.uio_in, pins.ui_in[3]};

  // stim toggles on the edge that enters DRIVE, so the DRIVE cycle counts toward the
  // measured round trip and an ideal loopback settles in exactly SYNC_STAGES cycles.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    mode_d      = mode_q;
    hold_err_d  = hold_err_q;
    max_delay_d = max_delay_q;
    delay_d     = delay_q;
    hold_d      = hold_q;
    lfsr_d      = lfsr_q;
    trans_d     = trans_q;
    err_inc     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_edge) begin
          trans_d     = {1'b0, pins.ui_in[7:4], 4'b0000} + 9'd16;
          mode_d      = pins.ui_in[2];
          max_delay_d = 4'd0;
          fail_d      = 1'b0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          stim_d      = ~stim_q;
          state_d     = DRIVE;
        end
      end
      DRIVE: begin
        trans_d    = trans_q - 9'd1;
        delay_d    = 4'd0;
        lfsr_d     = {lfsr_q[6:0], lfsr_fb};
        hold_err_d = 1'b0;
        state_d    = WAIT_RET;
      end
      WAIT_RET: begin
        delay_d = delay_inc;
        if (ret_ok) begin
          if (delay_inc > max_delay_q) max_delay_d = delay_inc;
          hold_d  = hold_load;
          state_d = HOLD;
        end else if (delay_inc == TIMEOUT_C) begin
          // A timeout already charges this transition, so HOLD must not charge it again.
          err_inc    = 1'b1;
          fail_d     = 1'b1;
          hold_err_d = 1'b1;
          hold_d     = hold_load;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!ret_ok && !hold_err_q) begin
          err_inc    = 1'b1;
          fail_d     = 1'b1;
          hold_err_d = 1'b1;
        end
        if (hold_q == 4'd1) begin
          if (trans_q == 9'd0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = 1'b0;
            state_d = DONE;
          end else begin
            stim_d  = ~stim_q;
            state_d = DRIVE;
          end
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q == IDLE || state_q == DONE) && start_edge) begin
      err_count_d = 8'd0;
    end else if (err_inc && err_count_q != 8'hFF) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      inv_sync_q   <= '1;
      start_sync_q <= '0;
      start_prev_q <= 1'b0;
      stim_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      mode_q       <= 1'b0;
      hold_err_q   <= 1'b0;
      max_delay_q  <= 4'd0;
      delay_q      <= 4'd0;
      hold_q       <= 4'd0;
      err_count_q  <= 8'd0;
      lfsr_q       <= 8'h01;
      trans_q      <= 9'd0;
    end else if (ena) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, which the
      // synchroniser chains depend on.
      inv_sync_q   <= {inv_sync_q[SYNC_STAGES-2:0], pins.ui_in[0]};
      start_sync_q <= {start_sync_q[SYNC_STAGES-2:0], pins.ui_in[1]};
      start_prev_q <= start_sync_q[SYNC_STAGES-1];
      state_q      <= state_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      mode_q       <= mode_d;
      hold_err_q   <= hold_err_d;
      max_delay_q  <= max_delay_d;
      delay_q      <= delay_d;
      hold_q       <= hold_d;
      err_count_q  <= err_count_d;
      lfsr_q       <= lfsr_d;
      trans_q      <= trans_d;
    end
  end

  assign pins.uo_out  = {max_delay_q, fail_q, done_q, busy_q, stim_q};
  assign pins.uio_out = err_count_q;
  assign pins.uio_oe  = 8'hFF;

endmodule
